// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register port: a write sets the pointer and then stores data bytes,
// and a read streams bytes from the pointer. SCL/SDA are oversampled by clk.
module i2c_slave_regs #(
  parameter logic [6:0] ADDRESS   = 7'h77,
  parameter logic [7:0] PTR_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_WR_PTR  = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_RD_ACK  = 3'd6;
  localparam logic [2:0] S_IGNORE  = 3'd7;

  logic       r_sclMeta, r_sclSync, r_sclDly;
  logic       r_sdaMeta, r_sdaSync, r_sdaDly;
  logic [2:0] r_state, r_ackNext;
  logic [1:0] r_ackPhase;
  logic [2:0] r_bitCnt;
  logic [6:0] r_shift;
  logic [7:0] r_ptr, r_wdata;
  logic       r_we, r_oe, r_busy;

  logic       w_sclRise, w_sclFall, w_start, w_stop, w_lastBit, w_reFire;
  logic [7:0] w_byte;

  // The synchronisers idle high so that leaving reset on a quiet bus raises no event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {r_sclMeta, r_sclSync, r_sclDly} <= 3'b111;
      {r_sdaMeta, r_sdaSync, r_sdaDly} <= 3'b111;
    end else begin
      {r_sclMeta, r_sclSync, r_sclDly} <= {scl_in, r_sclMeta, r_sclSync};
      {r_sdaMeta, r_sdaSync, r_sdaDly} <= {sda_in, r_sdaMeta, r_sdaSync};
    end
  end

  assign w_sclRise = r_sclSync & ~r_sclDly;
  assign w_sclFall = ~r_sclSync & r_sclDly;
  assign w_start   = r_sclSync & r_sclDly & r_sdaDly & ~r_sdaSync;
  assign w_stop    = r_sclSync & r_sclDly & ~r_sdaDly & r_sdaSync;
  assign w_byte    = {r_shift, r_sdaSync};
  assign w_lastBit = (r_bitCnt == 3'd7);

  // A transmit byte is fetched on the SCL fall that ends an ACK slot, in the same cycle as the load.
  assign w_reFire = w_sclFall &
                    (((r_state == S_ACK) && (r_ackPhase == 2'd2) && (r_ackNext == S_RD_DATA)) ||
                     ((r_state == S_RD_ACK) && (r_ackPhase == 2'd1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ackNext  <= S_IDLE;
      r_ackPhase <= 2'd0;
      r_bitCnt   <= 3'd0;
      r_shift    <= 7'd0;
      r_ptr      <= PTR_RESET;
      r_wdata    <= 8'd0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_ptr <= r_ptr + 8'd1;

      if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_bitCnt <= 3'd0;
        r_oe     <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_WR_PTR, S_WR_DATA: begin
            if (w_sclRise) begin
              r_shift  <= w_byte[6:0];
              r_bitCnt <= r_bitCnt + 3'd1;
              if (w_lastBit) begin
                r_ackPhase <= 2'd0;
                r_state    <= S_ACK;
                if (r_state == S_ADDR) begin
                  if (w_byte[7:1] == ADDRESS) begin
                    r_ackNext <= w_byte[0] ? S_RD_DATA : S_WR_PTR;
                    r_busy    <= 1'b1;
                  end else begin
                    r_state <= S_IGNORE;
                    r_busy  <= 1'b0;
                  end
                end else if (r_state == S_WR_PTR) begin
                  r_ptr     <= w_byte;
                  r_ackNext <= S_WR_DATA;
                end else begin
                  r_wdata   <= w_byte;
                  r_we      <= 1'b1;
                  r_ackNext <= S_WR_DATA;
                end
              end
            end
          end
          // Phase 0: drive after the 8th fall; 1: hold through the 9th rise; 2: release on the next fall.
          S_ACK: begin
            case (r_ackPhase)
              2'd0: if (w_sclFall) begin
                r_oe       <= 1'b1;
                r_ackPhase <= 2'd1;
              end
              2'd1: if (w_sclRise) r_ackPhase <= 2'd2;
              default: if (w_sclFall) begin
                r_state  <= r_ackNext;
                r_bitCnt <= 3'd0;
                if (r_ackNext == S_RD_DATA) begin
                  r_shift <= reg_rdata[6:0];
                  r_oe    <= ~reg_rdata[7];
                end else begin
                  r_oe <= 1'b0;
                end
              end
            endcase
          end
          S_RD_DATA: begin
            if (w_sclFall) begin
              r_bitCnt <= r_bitCnt + 3'd1;
              if (w_lastBit) begin
                r_oe       <= 1'b0;
                r_state    <= S_RD_ACK;
                r_ackPhase <= 2'd0;
              end else begin
                r_oe    <= ~r_shift[6];
                r_shift <= {r_shift[5:0], 1'b0};
              end
            end
          end
          // The pointer advances past every byte sent, whether the master ACKs it or not.
          S_RD_ACK: begin
            if (r_ackPhase == 2'd0) begin
              if (w_sclRise) begin
                r_ptr <= r_ptr + 8'd1;
                if (r_sdaSync) begin
                  r_state <= S_IGNORE;
                  r_busy  <= 1'b0;
                end else begin
                  r_ackPhase <= 2'd1;
                end
              end
            end else if (w_sclFall) begin
              r_shift  <= reg_rdata[6:0];
              r_oe     <= ~reg_rdata[7];
              r_state  <= S_RD_DATA;
              r_bitCnt <= 3'd0;
            end
          end
          S_IGNORE: begin
            r_oe   <= 1'b0;
            r_busy <= 1'b0;
          end
          default: r_oe <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe    = r_oe;
  assign reg_addr  = r_ptr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = w_reFire & reset;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master against i2c_slave_regs: directed scenarios plus random transactions,
// checked against a transaction-level model of the pointer, strobes and returned bytes.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaLine;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;
  int weCount = 0;
  int reCount = 0;
  logic [15:0] expWr[$];
  logic [7:0]  expRe[$];
  logic [7:0]  txData[$];
  logic [7:0]  modelPtr;
  logic [15:0] monWr;
  logic [7:0]  monRe;

  assign sdaLine   = sdaM & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_slave_regs #(.ADDRESS(7'h77), .PTR_RESET(8'h00)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sdaLine), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Offset so bus activity at multiples of T never lands on a clock edge.
  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must match the next entry the model queued, in order.
  always @(negedge clk) begin
    if (reg_we && reg_re) checkOutput("strobe_overlap", 1, 0);
    if (reg_we) begin
      weCount++;
      if (expWr.size() == 0) checkOutput("unexpected_we", 1, 0);
      else begin
        monWr = expWr.pop_front();
        checkOutput("we_addr", reg_addr, monWr[15:8]);
        checkOutput("we_data", reg_wdata, monWr[7:0]);
      end
    end
    if (reg_re) begin
      reCount++;
      if (expRe.size() == 0) checkOutput("unexpected_re", 1, 0);
      else begin
        monRe = expRe.pop_front();
        checkOutput("re_addr", reg_addr, monRe);
      end
    end
  end

  task automatic busStart();
    if (scl == 1'b0) begin
      sdaM = 1'b1; #(T);
      scl = 1'b1;  #(T);
    end
    sdaM = 1'b0; #(T);
    scl = 1'b0;  #(T);
  endtask

  task automatic busStop();
    sdaM = 1'b0; #(T);
    scl = 1'b1;  #(T);
    sdaM = 1'b1; #(T);
  endtask

  task automatic writeBit(input logic b);
    sdaM = b; #(T);
    scl = 1'b1; #(2*T);
    scl = 1'b0; #(T);
  endtask

  task automatic readBit(output logic b);
    sdaM = 1'b1; #(T);
    scl = 1'b1;  #(T);
    b = sdaLine; #(T);
    scl = 1'b0;  #(T);
  endtask

  task automatic sendChecked(input logic [7:0] d, input logic expNack, input string name);
    logic ack;
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(ack);
    checkOutput(name, ack, expNack);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      d = {d[6:0], b};
    end
    writeBit(nack);
  endtask

  task automatic endChecks();
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_oe", sda_oe, 0);
    checkOutput("ptr", reg_addr, modelPtr);
    checkOutput("wr_left", expWr.size(), 0);
    checkOutput("re_left", expRe.size(), 0);
  endtask

  // Write transaction: address, pointer, then the bytes in txData, then STOP.
  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] ptr);
    logic match;
    match = (a == 7'h77);
    busStart();
    sendChecked({a, 1'b0}, !match, "wr_addr");
    checkOutput("wr_busy", busy, match);
    sendChecked(ptr, !match, "wr_ptr");
    if (match) modelPtr = ptr;
    foreach (txData[i]) begin
      if (match) begin
        expWr.push_back({modelPtr, txData[i]});
        modelPtr = modelPtr + 8'd1;
      end
      sendChecked(txData[i], !match, "wr_data");
    end
    busStop();
    endChecks();
  endtask

  // Read transaction of n bytes, optionally preceded by a pointer write and repeated START.
  task automatic readTxn(input logic [6:0] a, input logic setPtr, input logic [7:0] ptr,
                         input int n, output logic [7:0] lastByte);
    logic match;
    logic [7:0] b, startPtr, idx;
    match = (a == 7'h77);
    lastByte = 8'h00;
    if (setPtr) begin
      busStart();
      sendChecked({a, 1'b0}, !match, "rd_waddr");
      sendChecked(ptr, !match, "rd_ptr");
      if (match) modelPtr = ptr;
    end
    busStart();
    startPtr = modelPtr;
    if (match) for (int i = 0; i < n; i++) expRe.push_back(startPtr + 8'(i));
    sendChecked({a, 1'b1}, !match, "rd_addr");
    checkOutput("rd_busy", busy, match);
    for (int i = 0; i < n; i++) begin
      recvByte(b, (i == n - 1));
      idx = startPtr + 8'(i);
      checkOutput("rd_byte", b, match ? mem[idx] : 8'hFF);
      lastByte = b;
    end
    if (match) modelPtr = startPtr + 8'(n);
    busStop();
    endChecks();
  endtask

  initial begin
    logic [7:0] rb, acc;
    logic       b;
    int         we0, re0, n;
    logic [6:0] a;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    modelPtr = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_oe", sda_oe, 0);
    checkOutput("rst_we", reg_we, 0);
    checkOutput("rst_re", reg_re, 0);
    checkOutput("rst_wdata", reg_wdata, 0);
    checkOutput("rst_ptr", reg_addr, 8'h00);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk) reset = 1'b1;
    #(4*T);

    // Two data bytes land at 0x10 and 0x11.
    we0 = weCount;
    txData = '{8'h12, 8'h34};
    applyStimulus(7'h77, 8'h10);
    checkOutput("T1_ptr", reg_addr, 8'h12);
    checkOutput("T1_we_count", weCount - we0, 2);

    // Pointer 0xD0, repeated START, single byte 0x55 read then NACK.
    mem[8'hD0] = 8'h55;
    re0 = reCount;
    readTxn(7'h77, 1'b1, 8'hD0, 1, rb);
    checkOutput("T2_byte", rb, 8'h55);
    checkOutput("T2_ptr", reg_addr, 8'hD1);
    checkOutput("T2_re_count", reCount - re0, 1);

    // Burst read wraps through 0xFF.
    re0 = reCount;
    readTxn(7'h77, 1'b1, 8'hFE, 3, rb);
    checkOutput("T3_ptr", reg_addr, 8'h01);
    checkOutput("T3_re_count", reCount - re0, 3);

    // Foreign address is ignored.
    txData = '{8'h99};
    we0 = weCount;
    applyStimulus(7'h50, 8'h44);
    checkOutput("T4_busy", busy, 0);
    checkOutput("T4_we_count", weCount - we0, 0);

    // STOP in the middle of a data byte discards it.
    we0 = weCount;
    busStart();
    sendChecked(8'hEE, 1'b0, "T5_addr");
    sendChecked(8'h20, 1'b0, "T5_ptr");
    modelPtr = 8'h20;
    writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
    busStop();
    endChecks();
    checkOutput("T5_we_count", weCount - we0, 0);
    txData = '{8'hAB};
    applyStimulus(7'h77, 8'h30);
    checkOutput("T5_next_ptr", reg_addr, 8'h31);

    // Reset while the target drives SDA low during a read.
    mem[8'h40] = 8'h00;
    busStart();
    sendChecked(8'hEE, 1'b0, "T6_addr");
    sendChecked(8'h40, 1'b0, "T6_ptr");
    modelPtr = 8'h40;
    busStart();
    expRe.push_back(8'h40);
    sendChecked(8'hEF, 1'b0, "T6_raddr");
    readBit(b);
    checkOutput("T6_bit7", b, 0);
    checkOutput("T6_oe_before", sda_oe, 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("T6_oe_after", sda_oe, 0);
    checkOutput("T6_ptr", reg_addr, 8'h00);
    checkOutput("T6_busy", busy, 0);
    @(negedge clk) reset = 1'b1;
    modelPtr = 8'h00;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      acc = {acc[6:0], b};
    end
    checkOutput("T6_released", acc, 8'hFF);
    busStop();
    endChecks();

    // Random mix of writes and reads, occasionally to a foreign address.
    for (int k = 0; k < 20; k++) begin
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'h77;
      if ($urandom_range(0, 1) == 0) begin
        txData.delete();
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) txData.push_back(8'($urandom));
        applyStimulus(a, 8'($urandom));
      end else begin
        readTxn(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3), rb);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) with a byte-wide register-port back end.
- Decodes START, repeated START and STOP on an oversampled SCL/SDA pair and matches its 7-bit address.
- Write transfers load an internal register pointer, then write data bytes; read transfers stream register bytes from the pointer.
- Serves as the bus-side counterpart of the team's I2C master driver: in simulation it emulates the BMP180 register map, and in fabric it exposes configuration registers.

Parameters:
- ADDRESS, 7'h77: own 7-bit target address.
- PTR_RESET, 8'h00: register pointer value after reset.

Ports:
- clk  input  1  system clock; must be at least 10x the SCL frequency.
- reset  input  1  synchronous, active-low.
- scl_in  input  1  SCL line level (asynchronous).
- sda_in  input  1  SDA line level (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  output  8  current register pointer.
- reg_wdata  output  8  received data byte.
- reg_we  output  1  one-clk write strobe.
- reg_re  output  1  one-clk strobe: byte at reg_addr fetched for transmit.
- reg_rdata  input  8  register read data; must be valid in the same cycle as reg_addr.
- busy  output  1  high from an address match until STOP, NACK or mismatch.

Behaviour:
- Synchronisers:
  - scl_in and sda_in each pass through 2 flops, then a third delay flop for edge detection.
  - All events below are single-clk pulses on the synchronised signals; latency from the pin is 3 clk.
- Bus events:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - SCL_RISE / SCL_FALL = edges of synchronised SCL.
- Reset values: state IDLE, sda_oe=0, reg_we=0, reg_re=0, reg_wdata=0, pointer=PTR_RESET, bit counter=0, busy=0. Reset mid-transfer releases SDA on the next clk edge.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift sda on each SCL_RISE, MSB first; 8 bits total.
    - On the 8th SCL_RISE, if bits[7:1]==ADDRESS go to ADDR_ACK with rw=bit0; otherwise go to IGNORE.
  - ADDR_ACK: set sda_oe=1 at the next SCL_FALL; hold through the 9th SCL_RISE; clear on the following SCL_FALL.
    - rw=0: go to WR_PTR.
    - rw=1: go to RD_DATA, loading the shift register from reg_rdata and pulsing reg_re in that same SCL_FALL cycle; sda_oe = !shift[7].
  - WR_PTR: receive 8 bits; pointer <= byte on the 8th SCL_RISE; ACK as above; then go to WR_DATA.
  - WR_DATA: receive 8 bits.
    - On the 8th SCL_RISE: reg_wdata <= byte and reg_we=1 for one clk, with reg_addr still equal to the old pointer.
    - Next clk: pointer <= pointer+1, wrapping 8'hFF to 8'h00.
    - ACK, then stay in WR_DATA.
  - RD_DATA: on each SCL_FALL, shift left and set sda_oe = !next MSB. After 8 bits, release SDA at the 8th SCL_FALL and go to RD_ACK.
  - RD_ACK: sample SDA at the 9th SCL_RISE.
    - 0 (ACK): pointer+1 (wrapping); at the next SCL_FALL load reg_rdata, pulse reg_re, return to RD_DATA.
    - 1 (NACK): go to IGNORE; pointer is already incremented past the last byte sent.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Priority in any state:
  - STOP: go to IDLE, sda_oe=0, busy=0.
  - START: go to ADDR, bit counter cleared, sda_oe=0.
  - The pointer is retained across repeated START and STOP.
- A STOP or START mid-byte discards the partial byte; no reg_we is issued.
- reg_we and reg_re are never high in the same cycle.
- busy:
  - Set on address match.
  - Cleared on entry to IDLE or IGNORE.
  - Stays high across a repeated START only if the new address matches.

Test Plan:
- Write 0xEE, 0x10, 0x12, 0x34, STOP -> ACK on all 4 bytes; reg_we pulses with (reg_addr, reg_wdata) = (0x10, 0x12) then (0x11, 0x34); final pointer 0x12.
- Write 0xEE, 0xD0, repeated START, 0xEF, master clocks 8 bits with reg_rdata=0x55 then NACK -> SDA driven 0,1,0,1,0,1,0,1; reg_re pulses once with reg_addr=0xD0; sda_oe=0 after the 8th bit and stays 0; pointer=0xD1.
- Burst read from pointer 0xFE, 3 bytes with ACK, ACK, NACK -> reg_re at reg_addr 0xFE, 0xFF, 0x00 (wrap); final pointer 0x01.
- Address 0xA0 (0x50, write) -> no ACK (sda_oe stays 0 during the 9th clock); busy=0; no strobes until the next START.
- STOP after 4 bits of a data byte -> no reg_we; state IDLE; a following valid transaction is ACKed normally.
- Assert reset while sda_oe=1 mid-read -> sda_oe=0 one clk later, pointer=0x00, state IDLE; no ACK on the rest of the byte.
